// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the EX/MEM register (master) and the
// multi-cycle data-memory responder (slave).
interface data_mem_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        readValid;
    logic        memStall;
    logic [1:0]  errStatus;
    logic [15:0] accessCount;

    modport master (
        output MemRead, MemWrite, address, writeData,
        input  readData, readValid, memStall, errStatus, accessCount
    );

    modport slave (
        input  MemRead, MemWrite, address, writeData,
        output readData, readValid, memStall, errStatus, accessCount
    );
endinterface

// File: rtl/data_mem_responder.sv
// MEM-stage data memory with a fixed number of wait states per access.
// Latches one word request in IDLE, counts down in WAIT, commits the access
// on the edge into RESPOND and holds the pipeline via a combinational stall.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic      clk,
    input  logic      reset,
    data_mem_if.slave bus
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  rd_q, wr_q;
    logic [31:0]           rdata_q;
    logic [1:0]            err_q;
    logic [15:0]           acc_q;

    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  accept;
    logic                  fire;
    logic                  aligned;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  unused_addr_hi;

    assign req     = bus.MemRead | bus.MemWrite;
    assign accept  = (state_q == S_IDLE) && req;
    // The access happens on the edge that leaves the last WAIT cycle.
    assign fire    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign aligned = (addr_q[1:0] == 2'b00);
    assign idx     = addr_q[ADDR_WIDTH+1:2];

    // Upper address bits are deliberately dropped so accesses wrap.
    assign unused_addr_hi = ^bus.address[31:ADDR_WIDTH+2];

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> WAIT (WAIT_STATES cycles) -> RESPOND -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Capture the request once at the IDLE edge; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.address[ADDR_WIDTH+1:0];
            wdata_q <= bus.writeData;
            rd_q    <= bus.MemRead;
            wr_q    <= bus.MemWrite;
        end
    end

    // Word store; misaligned writes are dropped. Contents survive reset.
    always_ff @(posedge clk) begin
        if (fire && wr_q && aligned) begin
            mem[idx] <= wdata_q;
        end
    end

    // Load data register; a combined read+write does not update it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (fire && rd_q && !wr_q) begin
            rdata_q <= aligned ? mem[idx] : 32'h0;
        end
    end

    // Sticky protocol error flags, set as the access completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 2'b00;
        end else if (fire) begin
            err_q <= err_q | {rd_q & wr_q, ~aligned};
        end
    end

    // Completed-access counter, bumped on the edge leaving RESPOND.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= 16'h0;
        end else if (state_q == S_RESP && acc_q != 16'hFFFF) begin
            acc_q <= acc_q + 16'h1;
        end
    end

    // Stall also covers the IDLE cycle in which the request first appears,
    // and is forced low while reset is held.
    assign bus.memStall    = reset & (accept | (state_q == S_WAIT));
    assign bus.readValid   = (state_q == S_RESP) & rd_q & ~wr_q;
    assign bus.readData    = rdata_q;
    assign bus.errStatus   = err_q;
    assign bus.accessCount = acc_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + randomized bench for data_mem_responder with a word-level
// reference model (associative memory, sticky flags, saturating count).
module tb_data_mem_responder;

    localparam int AW = 10;
    localparam int WS = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    data_mem_if bus();

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          npass  = 0;
    int          ntotal = 0;
    logic [31:0] mem_m [int];
    logic [31:0] rdata_m;
    logic [1:0]  err_m;
    int          acc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete access, starting just after a negedge in an IDLE cycle
    // and ending at the negedge of the following IDLE cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
        bit    aligned;
        int    idx;
        int    stalls;
        int    acc_old;
        logic  rv_exp;
        aligned = (addr % 4) == 0;
        idx     = int'((addr / 4) % (1 << AW));
        acc_old = acc_m;
        if (wr && aligned) mem_m[idx] = data;
        if (rd && !wr) rdata_m = aligned ? mem_m[idx] : 32'h0;
        err_m  = err_m | {rd && wr, !aligned};
        acc_m  = (acc_old < 65535) ? acc_old + 1 : acc_old;
        rv_exp = rd && !wr;

        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.address   = addr;
        bus.writeData = data;
        #1;
        chk("stall_on_request", bus.memStall, 1'b1);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.memStall) break;
            stalls++;
        end
        chk("wait_stall_cycles", stalls, WS);
        chk("readValid_respond", bus.readValid, rv_exp);
        chk("readData", bus.readData, rdata_m);
        chk("errStatus", bus.errStatus, err_m);
        chk("accessCount_respond", bus.accessCount, acc_old);
        @(negedge clk);
        chk("readValid_after", bus.readValid, 1'b0);
        chk("accessCount", bus.accessCount, acc_m);
        chk("readData_hold", bus.readData, rdata_m);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_readData"},    bus.readData, 32'h0);
        chk({tag, "_readValid"},   bus.readValid, 1'b0);
        chk({tag, "_memStall"},    bus.memStall, 1'b0);
        chk({tag, "_errStatus"},   bus.errStatus, 2'b00);
        chk({tag, "_accessCount"}, bus.accessCount, 16'h0);
    endtask

    initial begin
        logic        rd, wr;
        logic [31:0] a, d, u;
        logic [9:0]  ix;
        int          op;

        rdata_m = 32'h0;
        err_m   = 2'b00;
        acc_m   = 0;
        reset         = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.address   = 32'h0;
        bus.writeData = 32'h0;

        // Reset held for two cycles, then released with no requests.
        repeat (2) @(posedge clk);
        #1 chk_all_zero("in_reset");
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk_all_zero("after_reset");
        @(negedge clk);
        chk("idle_no_stall", bus.memStall, 1'b0);

        // Store then load the same word.
        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        chk("store_load_data", bus.readData, 32'hDEADBEEF);

        // Wrap-around: 0x1010 aliases word 4.
        access(1'b0, 1'b1, 32'h0000_1010, 32'h12345678);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        chk("wrap_data", bus.readData, 32'h12345678);

        // Misaligned read returns 0, flag stays set, word 4 untouched.
        access(1'b1, 1'b0, 32'h0000_0012, 32'h0);
        chk("misaligned_err", bus.errStatus, 2'b01);
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        chk("misaligned_sticky", bus.errStatus, 2'b01);

        // Simultaneous read+write: write only, no readValid.
        access(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        chk("both_err", bus.errStatus, 2'b11);

        // Reset during the first WAIT cycle of a write aborts it.
        access(1'b0, 1'b1, 32'h0000_0030, 32'h0BADF00D);
        bus.MemWrite  = 1'b1;
        bus.address   = 32'h0000_0030;
        bus.writeData = 32'hFFFFFFFF;
        #1 chk("abort_stall_req", bus.memStall, 1'b1);
        @(negedge clk);
        chk("abort_in_wait", bus.memStall, 1'b1);
        reset = 1'b0;
        #1 chk("abort_stall_drop", bus.memStall, 1'b0);
        chk("abort_count", bus.accessCount, 16'h0);
        chk("abort_err", bus.errStatus, 2'b00);
        chk("abort_rdata", bus.readData, 32'h0);
        bus.MemWrite = 1'b0;
        rdata_m = 32'h0;
        err_m   = 2'b00;
        acc_m   = 0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("abort_count_after", bus.accessCount, 16'h0);
        chk("abort_stall_after", bus.memStall, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0030, 32'h0);
        chk("abort_word_kept", bus.readData, 32'h0BADF00D);

        // Randomized mix over 16 words with random upper address bits.
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 9));
            ix = 10'($urandom_range(0, 15));
            u  = $urandom;
            a  = {u[31:12], ix, 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d  = $urandom;
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            if (rd && !wr && a[1:0] == 2'b00 && !mem_m.exists(int'(ix))) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            access(rd, wr, a, d);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
